// File: rtl/apb_spi_xfer_ctrl.sv
// APB-side sequencer for single SPI transfers: register file, four-phase req/ack
// handshake toward the SPI domain, watchdog, blocking wait states and interrupt.
module apb_spi_xfer_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [3:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              xfer_req,
  input  logic              xfer_ack,
  output logic [DATA_W-1:0] tx_data,
  input  logic [DATA_W-1:0] rx_data,
  output logic              irq
);

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_TXDATA = 4'h4;
  localparam logic [3:0] ADDR_RXDATA = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int               TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t              state;
  logic                ctrl_block;
  logic                ctrl_irq_en;
  logic                st_done;
  logic                st_tmo;
  logic [DATA_W-1:0]   rx_q;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                blk_q;
  logic                abort_q;

  logic access;
  logic start;
  logic blk_wait;
  logic wr_en;
  logic busy_err;
  logic blk_err;
  logic tmo_hit;
  logic unused_pwdata;

  assign unused_pwdata = ^pwdata;

  assign access   = psel & penable;
  assign start    = access & pwrite & (paddr == ADDR_TXDATA) & (state == S_IDLE);
  // A blocking start must stall its own access, so the start term is combinational.
  assign blk_wait = (blk_q & (state != S_DONE)) | (start & ctrl_block);
  assign pready   = access & ~blk_wait;
  assign wr_en    = access & pwrite & pready;

  // The held blocking access reports the abort; any other TXDATA write while busy errors.
  assign busy_err = access & pwrite & (paddr == ADDR_TXDATA) & (state != S_IDLE) & ~blk_q;
  assign blk_err  = access & blk_q & (state == S_DONE) & abort_q;
  assign pslverr  = busy_err | blk_err;

  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == CNT_LAST);

  // NOTE: every path assigns a default first so no latch is inferred.
  always_comb begin
    prdata = '0;
    if (access && !pwrite) begin
      case (paddr)
        ADDR_CTRL:   prdata = {30'd0, ctrl_irq_en, ctrl_block};
        ADDR_RXDATA: prdata = 32'(rx_q);
        ADDR_STATUS: prdata = {29'd0, st_tmo, st_done, (state != S_IDLE)};
        default:     prdata = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; a later assignment
  // to the same flag in this block wins, which gives set priority over W1C.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= S_IDLE;
      ctrl_block  <= 1'b0;
      ctrl_irq_en <= 1'b0;
      st_done     <= 1'b0;
      st_tmo      <= 1'b0;
      rx_q        <= '0;
      tmo_cnt     <= '0;
      blk_q       <= 1'b0;
      abort_q     <= 1'b0;
      xfer_req    <= 1'b0;
      tx_data     <= '0;
      irq         <= 1'b0;
    end else begin
      irq <= ctrl_irq_en & (st_done | st_tmo);

      if (wr_en && paddr == ADDR_CTRL) begin
        {ctrl_irq_en, ctrl_block} <= pwdata[1:0];
      end
      if (wr_en && paddr == ADDR_STATUS) begin
        if (pwdata[1]) st_done <= 1'b0;
        if (pwdata[2]) st_tmo  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            tx_data  <= pwdata[DATA_W-1:0];
            xfer_req <= 1'b1;
            tmo_cnt  <= '0;
            blk_q    <= ctrl_block;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (xfer_ack) begin
            rx_q     <= rx_data;
            xfer_req <= 1'b0;
            tmo_cnt  <= '0;
            state    <= S_RELEASE;
          end else if (tmo_hit) begin
            xfer_req <= 1'b0;
            abort_q  <= 1'b1;
            state    <= S_DONE;
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (!xfer_ack) begin
            state <= S_DONE;
          end else if (tmo_hit) begin
            abort_q <= 1'b1;
            state   <= S_DONE;
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (abort_q) st_tmo  <= 1'b1;
          else         st_done <= 1'b1;
          abort_q <= 1'b0;
          blk_q   <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
